approx_dot_accumulator: RTL

APPROX_DOT_ACCUMULATOR -- requirements
Module: approx_dot_accumulator

---
 rtl/approx_dot_accumulator_if.sv | 24 ++
 rtl/approx_dot_accumulator.sv | 108 ++++++++++
 2 files changed

// File: rtl/approx_dot_accumulator_if.sv
// Handshake bundle for the approximate dot-product accumulator: a product
// stream in, one saturated dot-product result out.
interface approx_dot_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_acc;
  logic              out_sat;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_acc, out_sat
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_acc, out_sat
  );
endinterface

// File: rtl/approx_dot_accumulator.sv
// Sums LEN unsigned products from an approximate multiplier into a saturating
// accumulator, then holds the result until the downstream consumer takes it.
module approx_dot_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int LEN    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  approx_dot_accumulator_if.slave    bus
);
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t            state, state_nxt;
  logic [ACC_W-1:0]  acc_p0, acc_nxt;
  logic              sat_p0, sat_nxt;
  logic [CNT_W-1:0]  cnt_p0, cnt_nxt;
  logic [ACC_W-1:0]  res_acc_p1, res_acc_nxt;
  logic              res_sat_p1, res_sat_nxt;
  logic              vld_p1, vld_nxt;
  logic [ACC_W:0]    add_res;
  logic              xfer_in;

  // MSB flags overflow; the lower ACC_W bits are already clamped to all-ones.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] p);
    logic [ACC_W:0] s;
    s = {1'b0, a} + (ACC_W+1)'(p);
    if (s[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return s;
  endfunction

  assign add_res      = sat_add(acc_p0, bus.in_prod);
  assign bus.in_ready = (state == ACCUM);
  assign xfer_in      = bus.in_valid && (state == ACCUM);
  assign bus.out_valid = vld_p1;
  assign bus.out_acc   = res_acc_p1;
  assign bus.out_sat   = res_sat_p1;

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc_p0;
    sat_nxt     = sat_p0;
    cnt_nxt     = cnt_p0;
    res_acc_nxt = res_acc_p1;
    res_sat_nxt = res_sat_p1;
    vld_nxt     = vld_p1;
    if (clear) begin
      state_nxt = ACCUM;
      acc_nxt   = '0;
      sat_nxt   = 1'b0;
      cnt_nxt   = '0;
      vld_nxt   = 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (xfer_in) begin
            acc_nxt = add_res[ACC_W-1:0];
            sat_nxt = sat_p0 | add_res[ACC_W];
            if (cnt_p0 == LAST) begin
              res_acc_nxt = add_res[ACC_W-1:0];
              res_sat_nxt = sat_p0 | add_res[ACC_W];
              vld_nxt     = 1'b1;
              cnt_nxt     = '0;
              state_nxt   = HOLD;
            end else begin
              cnt_nxt = cnt_p0 + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            vld_nxt   = 1'b0;
            acc_nxt   = '0;
            sat_nxt   = 1'b0;
            state_nxt = ACCUM;
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // Stage p0: running sum and count; stage p1: held result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACCUM;
      acc_p0     <= '0;
      sat_p0     <= 1'b0;
      cnt_p0     <= '0;
      res_acc_p1 <= '0;
      res_sat_p1 <= 1'b0;
      vld_p1     <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc_p0     <= acc_nxt;
      sat_p0     <= sat_nxt;
      cnt_p0     <= cnt_nxt;
      res_acc_p1 <= res_acc_nxt;
      res_sat_p1 <= res_sat_nxt;
      vld_p1     <= vld_nxt;
    end
  end
endmodule
